// File: rtl/shift4_seq_ctrl.sv
// Round-robin sequencer for a shared 4-bit shift register.
// Each granted word gets one load strobe, SHIFT_CNT enable strobes and a done pulse.
module shift4_seq_ctrl #(
    parameter int unsigned SHIFT_CNT = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_data0,
    input  logic [3:0] req_data1,
    output logic [1:0] req_ready,
    input  logic       hold,
    input  logic       abort,
    output logic       sr_load,
    output logic       sr_ena,
    output logic [3:0] sr_data,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       sr_data_nxt;
    logic             last_grant, last_grant_nxt;
    logic             gnt_id, gnt_id_nxt;
    logic             win_id;

    // With both requesters valid, the one not served last time wins.
    always_comb begin
        case (req_valid)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last_grant;
            default: win_id = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sr_data_nxt    = sr_data;
        last_grant_nxt = last_grant;
        gnt_id_nxt     = gnt_id;
        req_ready      = '0;
        sr_load        = 1'b0;
        sr_ena         = 1'b0;
        busy           = (state != IDLE);
        done           = 1'b0;
        done_id        = 1'b0;

        case (state)
            IDLE: begin
                // req_ready is gated by areset_n so every output reads 0 while reset is held.
                if (areset_n && !abort && (req_valid != 2'b00)) begin
                    req_ready      = win_id ? 2'b10 : 2'b01;
                    sr_data_nxt    = win_id ? req_data1 : req_data0;
                    gnt_id_nxt     = win_id;
                    last_grant_nxt = win_id;
                    cnt_nxt        = CNT_W'(SHIFT_CNT);
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                sr_load   = 1'b1;
                state_nxt = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!hold) begin
                    sr_ena  = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                done_id   = gnt_id;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr_data    <= '0;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr_data    <= sr_data_nxt;
            last_grant <= last_grant_nxt;
            gnt_id     <= gnt_id_nxt;
        end
    end

endmodule

// File: tb/tb_shift4_seq_ctrl.sv
// Bench for shift4_seq_ctrl: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model, for both a SHIFT_CNT=4 and a SHIFT_CNT=1 build.
module tb_shift4_seq_ctrl;

    logic       clk = 1'b0;
    logic       areset_n;
    logic [1:0] req_valid;
    logic [3:0] req_data0, req_data1;
    logic       hold, abort;

    logic [1:0] req_ready, req_ready1;
    logic       sr_load, sr_ena, busy, done, done_id;
    logic       sr_load1, sr_ena1, busy1, done1, done_id1;
    logic [3:0] sr_data, sr_data1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift4_seq_ctrl #(.SHIFT_CNT(4), .CNT_W(4)) dut (
        .clk(clk), .areset_n(areset_n), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .hold(hold), .abort(abort), .sr_load(sr_load), .sr_ena(sr_ena),
        .sr_data(sr_data), .busy(busy), .done(done), .done_id(done_id)
    );

    shift4_seq_ctrl #(.SHIFT_CNT(1), .CNT_W(4)) dut1 (
        .clk(clk), .areset_n(areset_n), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready1),
        .hold(hold), .abort(abort), .sr_load(sr_load1), .sr_ena(sr_ena1),
        .sr_data(sr_data1), .busy(busy1), .done(done1), .done_id(done_id1)
    );

    // Output vector layout: {ready[1:0], load, ena, data[3:0], busy, done, done_id}
    // Model: a transaction is active, first awaiting its load, then counting
    // remaining shifts, then reporting completion.
    typedef struct {
        bit         act;
        bit         ld;
        bit         dn;
        int         left;
        bit         gid;
        bit         last;
        logic [3:0] data;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.act = 0; m.ld = 0; m.dn = 0; m.left = 0;
        m.gid = 0; m.last = 1; m.data = 4'h0;
        return m;
    endfunction

    function automatic bit pick(mdl_t m, logic [1:0] v);
        if (v == 2'b11) return !m.last;
        return v[1];
    endfunction

    function automatic logic [10:0] mdl_out(mdl_t m, logic rst_n, logic [1:0] v,
                                            logic hold_i, logic abort_i);
        logic [1:0] rdy;
        logic       ena;
        if (!rst_n) return '0;
        rdy = 2'b00;
        if (!m.act && !abort_i && v != 2'b00) rdy = pick(m, v) ? 2'b10 : 2'b01;
        ena = m.act && !m.ld && !m.dn && !hold_i && !abort_i;
        return {rdy, m.act && m.ld, ena, m.data, m.act, m.act && m.dn,
                m.act && m.dn && m.gid};
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int n, logic rst_n, logic [1:0] v,
                                      logic [3:0] d0, logic [3:0] d1,
                                      logic hold_i, logic abort_i);
        mdl_t r;
        bit   w;
        r = m;
        if (!rst_n) return mdl_reset();
        if (!m.act) begin
            if (v != 2'b00 && !abort_i) begin
                w = pick(m, v);
                r.act = 1; r.ld = 1; r.dn = 0; r.left = n;
                r.gid = w; r.last = w; r.data = w ? d1 : d0;
            end
        end else if (m.ld) begin
            if (abort_i) r.act = 0;
            else         r.ld = 0;
        end else if (m.dn) begin
            r.act = 0; r.dn = 0;
        end else if (abort_i) begin
            r.act = 0;
        end else if (!hold_i) begin
            r.left = m.left - 1;
            if (r.left == 0) r.dn = 1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the models, return at posedge+1.
    task automatic cycle(output logic [10:0] o, output logic [10:0] o1);
        @(negedge clk);
        o  = {req_ready, sr_load, sr_ena, sr_data, busy, done, done_id};
        o1 = {req_ready1, sr_load1, sr_ena1, sr_data1, busy1, done1, done_id1};
        chk("cyc_n4", o,  mdl_out(m4, areset_n, req_valid, hold, abort));
        chk("cyc_n1", o1, mdl_out(m1, areset_n, req_valid, hold, abort));
        m4 = mdl_step(m4, 4, areset_n, req_valid, req_data0, req_data1, hold, abort);
        m1 = mdl_step(m1, 1, areset_n, req_valid, req_data0, req_data1, hold, abort);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [10:0] a, b;
        areset_n = 1'b0;
        m4 = mdl_reset();
        m1 = mdl_reset();
        cycle(a, b);
        areset_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        logic [10:0] a, b;
        req_valid = 2'b00; hold = 1'b0; abort = 1'b0;
        for (int i = 0; i < n; i++) cycle(a, b);
    endtask

    logic [10:0] o, o1;
    logic [10:0] tr [0:15];
    logic [10:0] tr1[0:15];
    logic [3:0]  ld_q[$];
    logic        dn_q[$];
    int          ena_cnt;
    logic        acc;

    initial begin
        areset_n = 1'b0; req_valid = 2'b00; req_data0 = 4'h0; req_data1 = 4'h0;
        hold = 1'b0; abort = 1'b0;
        m4 = mdl_reset(); m1 = mdl_reset();
        cycle(o, o1);
        req_valid = 2'b11;
        cycle(o, o1);
        chk("reset_outs_n4", o, 0);
        chk("reset_outs_n1", o1, 0);
        req_valid = 2'b00;
        areset_n = 1'b1;

        // Single request
        req_data0 = 4'hB;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k == 0) ? 2'b01 : 2'b00;
            cycle(tr[k], tr1[k]);
        end
        chk("single_ready", tr[0][10:9], 2'b01);
        chk("single_load", {tr[1][8], tr[1][6:3]}, {1'b1, 4'hB});
        chk("single_ena_run", {tr[2][7], tr[3][7], tr[4][7], tr[5][7]}, 4'hF);
        ena_cnt = 0;
        for (int k = 0; k < 10; k++) ena_cnt += int'(tr[k][7]);
        chk("single_ena_cnt", ena_cnt, 4);
        chk("single_no_overlap", tr[1][7] | tr[6][7] | tr[6][8], 0);
        chk("single_done", tr[6][1:0], 2'b10);
        chk("single_idle", {tr[6][2], tr[7][2]}, 2'b10);
        chk("n1_sequence", {tr1[1][8], tr1[2][7], tr1[3][1], tr1[4][2]}, 4'b1110);

        // Contention
        do_reset();
        req_valid = 2'b11; req_data0 = 4'h3; req_data1 = 4'hC;
        for (int k = 0; k < 30; k++) begin
            cycle(o, o1);
            if (o[8]) ld_q.push_back(o[6:3]);
            if (o[1]) dn_q.push_back(o[0]);
        end
        idle_cycles(10);
        chk("cont_counts", {ld_q.size() >= 3, dn_q.size() >= 3}, 2'b11);
        chk("cont_done_ids", {dn_q[0], dn_q[1], dn_q[2]}, 3'b010);
        chk("cont_data", {ld_q[0], ld_q[1], ld_q[2]}, 12'h3C3);

        // Hold during SHIFT
        req_data0 = 4'h5;
        for (int k = 0; k < 13; k++) begin
            req_valid = (k == 0) ? 2'b01 : 2'b00;
            hold = (k >= 4 && k <= 6);
            cycle(tr[k], tr1[k]);
        end
        hold = 1'b0;
        ena_cnt = 0;
        for (int k = 0; k < 13; k++) ena_cnt += int'(tr[k][7]);
        chk("hold_ena_cnt", ena_cnt, 4);
        chk("hold_ena_off", {tr[4][7], tr[5][7], tr[6][7]}, 0);
        chk("hold_done", {tr[6][1], tr[8][1], tr[9][1]}, 3'b001);
        acc = 1'b1;
        for (int k = 1; k <= 9; k++) acc &= (tr[k][6:3] == 4'h5);
        chk("hold_data_stable", acc, 1);

        // Abort after first enable, requester 1 pending
        req_data0 = 4'h7; req_data1 = 4'h9;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k == 0) ? 2'b01 : ((k <= 4) ? 2'b10 : 2'b00);
            abort = (k == 3);
            cycle(tr[k], tr1[k]);
        end
        abort = 1'b0;
        chk("abort_ena", {tr[2][7], tr[3][7]}, 2'b10);
        chk("abort_idle", {tr[4][2], tr[3][1] | tr[4][1] | tr[5][1]}, 2'b00);
        chk("abort_regrant", tr[4][10:9], 2'b10);
        chk("abort_data_kept", tr[4][6:3], 4'h7);
        chk("abort_next_load", {tr[5][8], tr[5][6:3]}, {1'b1, 4'h9});
        chk("abort_in_done_ignored", tr1[3][1], 1);
        idle_cycles(4);

        // Async reset mid-SHIFT, with last grant = 0 beforehand
        req_data0 = 4'h6; req_data1 = 4'hA;
        for (int k = 0; k < 3; k++) begin
            req_valid = (k == 0) ? 2'b01 : 2'b00;
            cycle(o, o1);
        end
        chk("pre_rst_busy", busy, 1);
        areset_n = 1'b0;
        m4 = mdl_reset(); m1 = mdl_reset();
        #2;
        chk("async_rst_n4", {req_ready, sr_load, sr_ena, sr_data, busy, done, done_id}, 0);
        chk("async_rst_n1", {req_ready1, sr_load1, sr_ena1, sr_data1, busy1, done1, done_id1}, 0);
        cycle(o, o1);
        areset_n = 1'b1;
        req_valid = 2'b11;
        cycle(o, o1);
        chk("post_rst_grant", o[10:9], 2'b01);
        idle_cycles(10);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = 4'($urandom_range(0, 15));
            req_data1 = 4'($urandom_range(0, 15));
            hold  = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 19) == 0) && !(m4.act && m4.ld) && !(m1.act && m1.ld);
            cycle(o, o1);
        end
        idle_cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift4_seq_ctrl.md
Name: shift4_seq_ctrl

Overview:
- Sequencer and arbiter for a single 4-bit shift register (load/ena/data interface).
- Two requesters each offer a 4-bit word over valid/ready. Grants are round-robin.
- For each granted word: one load pulse, then exactly SHIFT_CNT enable pulses (stallable by `hold`), then a one-cycle `done` carrying the requester id.
- Sits between the requesting producers and the shared shift-register instance. Drives its load/ena/data inputs directly.

Parameters:
- SHIFT_CNT, 4, number of sr_ena pulses issued per transaction; legal range 1..15.
- CNT_W, 4, width of the internal shift counter; must hold SHIFT_CNT.

Ports:
- clk        input   1   rising-edge clock
- areset_n   input   1   asynchronous, active-low reset
- req_valid  input   2   bit i: requester i offers a word
- req_data0  input   4   word from requester 0
- req_data1  input   4   word from requester 1
- req_ready  output  2   bit i: requester i's word is accepted this cycle (combinational)
- hold       input   1   stall; suppresses sr_ena while high
- abort      input   1   synchronous cancel of the current transaction
- sr_load    output  1   load strobe to the shift register
- sr_ena     output  1   shift-enable strobe to the shift register
- sr_data    output  4   word presented to the shift register (registered)
- busy       output  1   high whenever state != IDLE
- done       output  1   one-cycle completion pulse
- done_id    output  1   requester id of the completed transaction; valid while done=1

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE, held in a registered state variable.
- Reset (areset_n=0, asynchronous) forces:
  - state=IDLE, cnt=0, sr_data=0, last_grant=1, gnt_id=0;
  - all outputs 0 (req_ready, sr_load, sr_ena, busy, done, done_id).
- Grant, IDLE only, abort=0 (combinational):
  - one requester valid: that requester wins;
  - both valid: the requester != last_grant wins;
  - req_ready is one-hot to the winner and 0 in every other state;
  - handshake = req_valid[i] & req_ready[i].
- On handshake at edge E0:
  - sr_data <= winner's data; gnt_id <= i; last_grant <= i;
  - cnt <= SHIFT_CNT; state <= LOAD.
- LOAD:
  - sr_load=1 for exactly one cycle (the shift register captures sr_data at E1);
  - state <= SHIFT unconditionally, unless abort.
- SHIFT:
  - sr_ena = ~hold (combinational).
  - Each cycle with sr_ena=1 decrements cnt.
  - When sr_ena=1 and cnt==1: state <= DONE.
  - hold=1: no decrement, state held.
- DONE: done=1 and done_id=gnt_id for one cycle, then state <= IDLE.
- Timing:
  - no hold: handshake-to-IDLE = SHIFT_CNT+3 cycles; sr_load and sr_ena never high together;
  - next grant is possible in the first IDLE cycle after DONE.
- abort=1:
  - in LOAD or SHIFT: state <= IDLE next edge, no done, sr_ena forced 0 that cycle; sr_data retains its value;
  - in IDLE: req_ready=0 that cycle;
  - in DONE: ignored (done still issued).
- sr_data is stable from LOAD through DONE. It changes only on a handshake or reset.
- Async reset mid-transaction: immediate return to reset values; the transaction is lost with no done.
- Arithmetic: cnt is unsigned CNT_W; it never wraps because the state leaves SHIFT at cnt==1.

Test Plan:
- Single request: reset, req_valid=01, req_data0=4'hB, SHIFT_CNT=4, hold=0 ->
  - req_ready=01 for one cycle; sr_load=1 next cycle with sr_data=B;
  - sr_ena=1 for 4 consecutive cycles; done=1, done_id=0; back to IDLE after 7 cycles total.
- Contention: req_valid=11 held across 3 transactions with data0=4'h3, data1=4'hC ->
  - grants alternate 0, 1, 0 (first grant to 0 after reset);
  - done_id sequence is 0, 1, 0; sr_data is 3, C, 3.
- Hold during SHIFT: hold=1 for 3 cycles after the 2nd sr_ena ->
  - sr_ena=0 during the hold; exactly 4 sr_ena pulses total;
  - done delayed by 3 cycles; sr_data unchanged.
- Abort: abort=1 in the cycle after the 1st sr_ena ->
  - next cycle IDLE, busy=0, no done;
  - a pending req_valid=10 is granted in the following cycle.
- Async reset: areset_n=0 mid-SHIFT between clock edges ->
  - outputs 0 immediately (before the next edge);
  - after release, the first grant with both requesters valid goes to requester 0.
- SHIFT_CNT=1 build: one request -> sr_load, one sr_ena, done on consecutive cycles (3 cycles total).
